in_port_fifo: RTL and testbench
===============================

Name: in_port_fifo

Overview:
- Input-side counterpart of the output port: external device pushes words in, processor pulls them onto the bus during the `in` instruction.
- Device side uses a valid/ready handshake into a DEPTH-entry FIFO.
- Datapath side: InIn pops the FIFO head into the In-port holding register. IN_Portout drives that register onto the bus through the bus mux.

Parameters:
- WIDTH, 32, data word width (bus width).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous active-high reset
- dev_data  in  WIDTH  word from external device
- dev_valid  in  1  device has a word on dev_data
- dev_ready  out  1  FIFO can accept; transfer when dev_valid && dev_ready at clk edge
- InIn  in  1  control: pop FIFO head into holding register
- IN_Portout  in  1  control: drive holding register onto bus
- bus_out  out  WIDTH  holding register when IN_Portout=1, else 0 (OR-able into bus mux)
- in_reg  out  WIDTH  holding register contents (debug/visibility)
- data_avail  out  1  FIFO not empty
- count  out  AW+1  FIFO occupancy, 0..DEPTH
- underflow  out  1  sticky: InIn asserted while empty
- overflow  out  1  sticky: dev_valid asserted while full

Behaviour:
Reset
- clr=1 at a clock edge clears: wr_ptr, rd_ptr, count, in_reg, underflow, overflow.
- dev_ready is combinational: !full && !clr. It is therefore 0 while clr is high and 1 on the first cycle after reset.
- clr wins over every simultaneous push, pop or flag set. Words held in the FIFO at reset are discarded.

Push
- Occurs at a clock edge when dev_valid && dev_ready.
- mem[wr_ptr] <= dev_data; wr_ptr increments modulo DEPTH (natural wrap, AW bits).

Pop
- Occurs at a clock edge when InIn && !empty.
- in_reg <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Latency: the popped word is visible on in_reg and bus_out (if IN_Portout=1) in the cycle after the InIn edge.

Occupancy and flags
- count: +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
- empty = (count==0); full = (count==DEPTH); data_avail = !empty.

Boundary conditions
- Full: dev_ready=0, no push. If dev_valid=1 at that edge, overflow sets (sticky until clr).
- Empty with InIn=1: no pop, in_reg unchanged, underflow sets (sticky until clr).
- Empty with push and InIn in the same cycle: push occurs, pop does not (no bypass), underflow sets; count becomes 1.
- Partially filled with push and InIn in the same cycle: both occur, count unchanged, FIFO order preserved.
- InIn held high across several cycles: one pop per cycle while non-empty.
- bus_out is purely combinational from IN_Portout and in_reg. A pop and IN_Portout in the same cycle drive the old in_reg value.
- Reading in_reg never alters FIFO state; only InIn pops.

Test Plan:
- Reset: hold clr 2 cycles with dev_valid=1 -> count=0, dev_ready=0 during clr and 1 after, in_reg=0, bus_out=0, flags=0.
- In-order transfer: push 0x11, 0x22, 0x33 -> count=3. Then InIn for 1 cycle each with IN_Portout=1 the following cycle -> bus_out shows 0x11, 0x22, 0x33 in turn; count returns to 0; data_avail falls after the third pop.
- Full/overflow: push 0xA0..0xA3 -> count=4, dev_ready=0. Then dev_valid=1 with dev_data=0xFF -> overflow=1, count stays 4. Four pops -> 0xA0..0xA3, no 0xFF.
- Underflow and same-cycle push on empty: InIn=1 with dev_valid=1, dev_data=0x5A on an empty FIFO -> underflow=1, in_reg unchanged, count=1. Next InIn -> in_reg=0x5A.
- Wrap and simultaneous push/pop: fill 3, then 6 cycles of push 0xB0..0xB5 with InIn=1 each cycle -> count holds at 3, pointers wrap, popped sequence preserves FIFO order.
- Reset mid-operation: count=2, assert clr together with InIn and dev_valid -> count=0, in_reg=0, no pop, flags cleared.

Source files
------------

// File: rtl/in_port_fifo_if.sv
// Handshake and bus bundle for the input-port FIFO.
// The master side is the device/sequencer that drives words and control;
// the slave side is the FIFO block itself.
interface in_port_fifo_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 2
);
   logic [WIDTH-1:0] dev_data;
   logic             dev_valid;
   logic             dev_ready;
   logic             InIn;
   logic             IN_Portout;
   logic [WIDTH-1:0] bus_out;
   logic [WIDTH-1:0] in_reg;
   logic             data_avail;
   logic [AW:0]      count;
   logic             underflow;
   logic             overflow;

   modport master (
      output dev_data, dev_valid, InIn, IN_Portout,
      input  dev_ready, bus_out, in_reg, data_avail, count, underflow, overflow
   );

   modport slave (
      input  dev_data, dev_valid, InIn, IN_Portout,
      output dev_ready, bus_out, in_reg, data_avail, count, underflow, overflow
   );
endinterface

// File: rtl/in_port_fifo.sv
// Input port: a device pushes words into a small FIFO through valid/ready,
// the processor pops the head into a holding register (InIn) and gates that
// register onto the bus (IN_Portout). Storage is a plain array so it can map
// to RAM; the only read of it is registered into the holding register.
module in_port_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic clk,
   input logic clr,
   in_port_fifo_if.slave io
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] in_reg_reg;
   logic             underflow_reg;
   logic             overflow_reg;

   logic empty;
   logic full;
   logic push;
   logic pop;

   // Occupancy decode and transfer qualification; reset suppresses any push.
   always_comb begin
      empty = (count_reg == '0);
      full  = (count_reg == (AW+1)'(DEPTH));
      push  = io.dev_valid && !full && !clr;
      pop   = io.InIn && !empty;
   end

   // Storage write; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= io.dev_data;
   end

   // Pointers, occupancy, holding register and sticky error flags.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         in_reg_reg    <= '0;
         underflow_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            in_reg_reg <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (io.InIn && empty)
            underflow_reg <= 1'b1;
         if (io.dev_valid && full)
            overflow_reg <= 1'b1;
      end
   end

   // Bus drive is an AND gate per bit so it can be ORed into the bus mux.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bus
         assign io.bus_out[gi] = io.IN_Portout & in_reg_reg[gi];
      end
   endgenerate

   assign io.dev_ready  = !full && !clr;
   assign io.in_reg     = in_reg_reg;
   assign io.data_avail = !empty;
   assign io.count      = count_reg;
   assign io.underflow  = underflow_reg;
   assign io.overflow   = overflow_reg;

endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: a directed vector table walking through reset,
// ordered transfer, full/overflow, underflow, wrap and mid-run reset, then
// random traffic compared against a queue-based model of the port.
module tb_in_port_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic clr;

   in_port_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

   in_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .clr (clr),
      .io  (bus_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        clr;
      logic        v;
      logic [31:0] d;
      logic        inin;
      logic        po;
      logic        chk;
      logic        rdy;
      logic [31:0] bus;
      logic [2:0]  cnt;
      logic [31:0] inr;
      logic        uf;
      logic        of;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic c, input logic v, input logic [31:0] d,
                      input logic inin, input logic po, input logic chk,
                      input logic rdy, input logic [31:0] bus, input logic [2:0] cnt,
                      input logic [31:0] inr, input logic uf, input logic of);
      vec_t r;
      r.clr = c; r.v = v; r.d = d; r.inin = inin; r.po = po; r.chk = chk;
      r.rdy = rdy; r.bus = bus; r.cnt = cnt; r.inr = inr; r.uf = uf; r.of = of;
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic v, input logic [31:0] d,
                        input logic inin, input logic po);
      clr               = c;
      bus_if.dev_valid  = v;
      bus_if.dev_data   = d;
      bus_if.InIn       = inin;
      bus_if.IN_Portout = po;
   endtask

   // Behavioural model for the random phase.
   logic [31:0] q[$];
   logic [31:0] m_in;
   logic        m_uf, m_of;

   initial begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

      //   clr v  data  InIn po chk   rdy bus   cnt inreg uf of
      add(1, 1, 32'h99, 0, 0, 0,    0, 32'h0, 0, 32'h0, 0, 0);
      add(1, 1, 32'h99, 0, 1, 1,    0, 32'h0, 0, 32'h0, 0, 0);
      // ordered transfer
      add(0, 1, 32'h11, 0, 0, 1,    1, 32'h0, 0, 32'h0, 0, 0);
      add(0, 1, 32'h22, 0, 0, 1,    1, 32'h0, 1, 32'h0, 0, 0);
      add(0, 1, 32'h33, 0, 0, 1,    1, 32'h0, 2, 32'h0, 0, 0);
      add(0, 0, 32'h0,  1, 0, 1,    1, 32'h0, 3, 32'h0, 0, 0);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'h11, 2, 32'h11, 0, 0);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'h22, 1, 32'h22, 0, 0);
      add(0, 0, 32'h0,  0, 1, 1,    1, 32'h33, 0, 32'h33, 0, 0);
      // fill to full, then overflow attempt
      add(0, 1, 32'hA0, 0, 0, 1,    1, 32'h0, 0, 32'h33, 0, 0);
      add(0, 1, 32'hA1, 0, 0, 1,    1, 32'h0, 1, 32'h33, 0, 0);
      add(0, 1, 32'hA2, 0, 0, 1,    1, 32'h0, 2, 32'h33, 0, 0);
      add(0, 1, 32'hA3, 0, 0, 1,    1, 32'h0, 3, 32'h33, 0, 0);
      add(0, 1, 32'hFF, 0, 0, 1,    0, 32'h0, 4, 32'h33, 0, 0);
      add(0, 0, 32'h0,  1, 0, 1,    0, 32'h0, 4, 32'h33, 0, 1);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'hA0, 3, 32'hA0, 0, 1);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'hA1, 2, 32'hA1, 0, 1);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'hA2, 1, 32'hA2, 0, 1);
      add(0, 0, 32'h0,  0, 1, 1,    1, 32'hA3, 0, 32'hA3, 0, 1);
      // underflow with simultaneous push on empty
      add(0, 1, 32'h5A, 1, 0, 1,    1, 32'h0, 0, 32'hA3, 0, 1);
      add(0, 0, 32'h0,  1, 0, 1,    1, 32'h0, 1, 32'hA3, 1, 1);
      add(0, 0, 32'h0,  0, 1, 1,    1, 32'h5A, 0, 32'h5A, 1, 1);
      // fill three, then push+pop every cycle across the pointer wrap
      add(0, 1, 32'hC0, 0, 0, 1,    1, 32'h0, 0, 32'h5A, 1, 1);
      add(0, 1, 32'hC1, 0, 0, 1,    1, 32'h0, 1, 32'h5A, 1, 1);
      add(0, 1, 32'hC2, 0, 0, 1,    1, 32'h0, 2, 32'h5A, 1, 1);
      add(0, 1, 32'hB0, 1, 0, 1,    1, 32'h0, 3, 32'h5A, 1, 1);
      add(0, 1, 32'hB1, 1, 1, 1,    1, 32'hC0, 3, 32'hC0, 1, 1);
      add(0, 1, 32'hB2, 1, 1, 1,    1, 32'hC1, 3, 32'hC1, 1, 1);
      add(0, 1, 32'hB3, 1, 1, 1,    1, 32'hC2, 3, 32'hC2, 1, 1);
      add(0, 1, 32'hB4, 1, 1, 1,    1, 32'hB0, 3, 32'hB0, 1, 1);
      add(0, 1, 32'hB5, 1, 1, 1,    1, 32'hB1, 3, 32'hB1, 1, 1);
      add(0, 0, 32'h0,  1, 1, 1,    1, 32'hB2, 3, 32'hB2, 1, 1);
      // reset in the middle of traffic wins over push and pop
      add(1, 1, 32'hEE, 1, 1, 1,    0, 32'hB3, 2, 32'hB3, 1, 1);
      add(0, 0, 32'h0,  0, 1, 1,    1, 32'h0, 0, 32'h0, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].inin, tbl[i].po);
         #1;
         check($sformatf("vec%0d.dev_ready", i), 64'(bus_if.dev_ready), 64'(tbl[i].rdy));
         if (tbl[i].chk) begin
            check($sformatf("vec%0d.bus_out", i), 64'(bus_if.bus_out), 64'(tbl[i].bus));
            check($sformatf("vec%0d.count", i), 64'(bus_if.count), 64'(tbl[i].cnt));
            check($sformatf("vec%0d.in_reg", i), 64'(bus_if.in_reg), 64'(tbl[i].inr));
            check($sformatf("vec%0d.data_avail", i), 64'(bus_if.data_avail), 64'(tbl[i].cnt != 0));
            check($sformatf("vec%0d.underflow", i), 64'(bus_if.underflow), 64'(tbl[i].uf));
            check($sformatf("vec%0d.overflow", i), 64'(bus_if.overflow), 64'(tbl[i].of));
         end
         $display("vec %0d: clr=%0b v=%0b d=%0h InIn=%0b po=%0b count=%0d in_reg=%0h bus=%0h",
                  i, tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].inin, tbl[i].po,
                  bus_if.count, bus_if.in_reg, bus_if.bus_out);
      end

      // Random phase: the previous row left the port freshly reset.
      q.delete();
      m_in = '0;
      m_uf = 1'b0;
      m_of = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic        r_clr, r_v, r_in, r_po;
         logic [31:0] r_d;
         logic        do_pop;
         r_clr = ($urandom_range(0, 49) == 0);
         r_v   = ($urandom_range(0, 99) < 55);
         r_in  = ($urandom_range(0, 99) < 45);
         r_po  = $urandom_range(0, 1) == 1;
         r_d   = $urandom;
         @(negedge clk);
         drive(r_clr, r_v, r_d, r_in, r_po);
         #1;
         check("rnd.dev_ready", 64'(bus_if.dev_ready), 64'(!r_clr && q.size() < DEPTH));
         check("rnd.bus_out", 64'(bus_if.bus_out), 64'(r_po ? m_in : 32'h0));
         check("rnd.count", 64'(bus_if.count), 64'(q.size()));
         check("rnd.in_reg", 64'(bus_if.in_reg), 64'(m_in));
         check("rnd.data_avail", 64'(bus_if.data_avail), 64'(q.size() != 0));
         check("rnd.underflow", 64'(bus_if.underflow), 64'(m_uf));
         check("rnd.overflow", 64'(bus_if.overflow), 64'(m_of));
         // Model the effect of the coming edge.
         if (r_clr) begin
            q.delete();
            m_in = '0;
            m_uf = 1'b0;
            m_of = 1'b0;
            $display("rnd %0d: reset", n);
         end else begin
            if (r_v && q.size() == DEPTH) m_of = 1'b1;
            if (r_in && q.size() == 0)    m_uf = 1'b1;
            do_pop = r_in && q.size() > 0;
            if (r_v && q.size() < DEPTH) q.push_back(r_d);
            if (do_pop) begin
               m_in = q.pop_front();
               $display("rnd %0d: pop %0h (occupancy now %0d)", n, m_in, q.size());
            end
         end
      end

      @(negedge clk);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
